freq_reduce_mc: RTL and testbench

- Multi-channel, runtime-programmable successor to the single-channel VCO frequency reducer.
- Each of NUM_CH asynchronous VCO inputs is synchronised and rising-edge detected. Every Nth edge (N = i_div) emits a spike of i_spike_len sys_clk cycles.
- Sits between the PMOD VCO inputs and the SNN input layer.
- Adds behaviour the single-channel version lacks: clean sync/edge detection, live ratio/length programming, enable gating, retrigger with sticky miss flags, and reset.

---
 rtl/freq_reduce_mc_if.sv | 37 +++
 rtl/freq_reduce_mc.sv | 125 ++++++++++++
 tb/tb_freq_reduce_mc.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_reduce_mc_if.sv
// Signal bundle between the VCO front end / control registers and freq_reduce_mc.
// Build macro FREQ_REDUCE_RATE_CNT_EN adds the o_rate_cnt spike counters.
interface freq_reduce_mc_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int LEN_W  = 8
);
  // No valid/ready pairs: every input is level-sampled on each sys_clk edge,
  // i_clr_status is a one-cycle strobe, and outputs are registered levels.
  logic [NUM_CH-1:0]       i_vco;
  logic                    i_en;
  logic [DIV_W-1:0]        i_div;
  logic [LEN_W-1:0]        i_spike_len;
  logic                    i_clr_status;
  logic [NUM_CH-1:0]       o_spike;
  logic [NUM_CH-1:0]       o_miss;
  logic [NUM_CH*DIV_W-1:0] o_edge_cnt;
`ifdef FREQ_REDUCE_RATE_CNT_EN
  logic [NUM_CH*32-1:0]    o_rate_cnt;
`endif

  modport master (
    output i_vco, i_en, i_div, i_spike_len, i_clr_status,
`ifdef FREQ_REDUCE_RATE_CNT_EN
    input  o_rate_cnt,
`endif
    input  o_spike, o_miss, o_edge_cnt
  );

  modport slave (
    input  i_vco, i_en, i_div, i_spike_len, i_clr_status,
`ifdef FREQ_REDUCE_RATE_CNT_EN
    output o_rate_cnt,
`endif
    output o_spike, o_miss, o_edge_cnt
  );
endinterface

// File: rtl/freq_reduce_mc.sv
// Multi-channel VCO frequency reducer: every i_div-th VCO rising edge emits an i_spike_len-cycle spike.
// Build macro FREQ_REDUCE_RATE_CNT_EN adds per-channel saturating spike counters on o_rate_cnt.
module freq_reduce_mc #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LEN_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  freq_reduce_mc_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_HIGH = 1'b1} spk_state_e;

  logic                    div_nz;
  logic                    len_nz;
  logic [DIV_W:0]          div_m1;
  logic [LEN_W-1:0]        len_m1;
  logic [NUM_CH-1:0]       spike_v;
  logic [NUM_CH-1:0]       miss_v;
  logic [NUM_CH*DIV_W-1:0] cnt_v;
`ifdef FREQ_REDUCE_RATE_CNT_EN
  logic [NUM_CH*32-1:0]    rate_v;
`endif

  assign div_nz = |bus.i_div;
  assign len_nz = |bus.i_spike_len;
  // One extra bit so i_div = 0 gives all-ones rather than wrapping into range.
  assign div_m1 = {1'b0, bus.i_div} - {{DIV_W{1'b0}}, 1'b1};
  assign len_m1 = bus.i_spike_len - LEN_W'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_q;
    logic [DIV_W-1:0]       cnt_q;
    logic [DIV_W-1:0]       cnt_d;
    logic [LEN_W-1:0]       len_q;
    spk_state_e             state_q;
    logic                   miss_q;
    logic                   fire;
    logic                   retrig;

    // Synchronisers run regardless of i_en so enabling mid-high sees no edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync_q <= '0;
        hist_q <= 1'b0;
        edge_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_vco[c]};
        hist_q <= sync_q[SYNC_STAGES-1];
        edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
    end

    assign fire   = edge_q & bus.i_en & div_nz & ({1'b0, cnt_q} >= div_m1);
    assign retrig = fire & len_nz & (state_q == S_HIGH);

    always_comb begin
      cnt_d = cnt_q;
      if (!bus.i_en || !div_nz) cnt_d = '0;
      else if (fire)            cnt_d = '0;
      else if (edge_q)          cnt_d = cnt_q + DIV_W'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        cnt_q   <= '0;
        len_q   <= '0;
        state_q <= S_IDLE;
        miss_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        miss_q <= (miss_q & ~bus.i_clr_status) | retrig;
        if (!bus.i_en) begin
          state_q <= S_IDLE;
          len_q   <= '0;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (fire && len_nz) begin
                state_q <= S_HIGH;
                len_q   <= len_m1;
              end
            end
            S_HIGH: begin
              if (fire && len_nz)  len_q   <= len_m1;
              else if (len_q == '0) state_q <= S_IDLE;
              else                  len_q   <= len_q - LEN_W'(1);
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end

    assign spike_v[c]                = (state_q == S_HIGH);
    assign miss_v[c]                 = miss_q;
    assign cnt_v[c*DIV_W +: DIV_W]   = cnt_q;

`ifdef FREQ_REDUCE_RATE_CNT_EN
    logic [31:0] rate_q;
    logic        start;

    // Only IDLE->HIGH transitions count; retriggers stretch an existing spike.
    assign start = fire & len_nz & (state_q == S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                 rate_q <= '0;
      else if (bus.i_clr_status)      rate_q <= {31'b0, start};
      else if (start && rate_q != '1) rate_q <= rate_q + 32'd1;
    end

    assign rate_v[c*32 +: 32] = rate_q;
`endif
  end

  assign bus.o_spike    = spike_v;
  assign bus.o_miss     = miss_v;
  assign bus.o_edge_cnt = cnt_v;
`ifdef FREQ_REDUCE_RATE_CNT_EN
  assign bus.o_rate_cnt = rate_v;
`endif
endmodule

// File: tb/tb_freq_reduce_mc.sv
// Testbench for freq_reduce_mc: directed scenarios plus randomised multi-channel traffic
// checked against a cycle-level behavioural model of the edge divider and spike timing.
module tb_freq_reduce_mc;
  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 16;
  localparam int LEN_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_reduce_mc_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LEN_W(LEN_W)) bus ();

  freq_reduce_mc #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LEN_W(LEN_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // VCO generators: periodic square wave per channel, OR-ed with a manual level.
  int                gen_per [NUM_CH];
  int                gen_hi  [NUM_CH];
  int                gen_ph  [NUM_CH];
  logic [NUM_CH-1:0] man;

  // Behavioural model: rising edges become effective LAT-1 edges after they are sampled.
  bit          m_vprev [NUM_CH];
  bit          m_dl    [NUM_CH][LAT-1];
  int          m_cnt   [NUM_CH];
  int          m_rem   [NUM_CH];
  bit          m_miss  [NUM_CH];
  int unsigned m_rate  [NUM_CH];

  function automatic logic [NUM_CH-1:0] m_spike_v();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (m_rem[c] > 0);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] m_miss_v();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_miss[c];
    return r;
  endfunction

  function automatic logic [NUM_CH*DIV_W-1:0] m_cnt_v();
    logic [NUM_CH*DIV_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DIV_W +: DIV_W] = DIV_W'(m_cnt[c]);
    return r;
  endfunction

  function automatic logic [NUM_CH*32-1:0] m_rate_v();
    logic [NUM_CH*32-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*32 +: 32] = m_rate[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_vprev[c] = 1'b0;
      for (int j = 0; j < LAT-1; j++) m_dl[c][j] = 1'b0;
      m_cnt[c]  = 0;
      m_rem[c]  = 0;
      m_miss[c] = 1'b0;
      m_rate[c] = 0;
    end
  endtask

  // Applied at every active edge with the input values that edge samples.
  task automatic model_step();
    bit rise, ev, fire, retrig, start;
    int div, len;
    div = int'(bus.i_div);
    len = int'(bus.i_spike_len);
    for (int c = 0; c < NUM_CH; c++) begin
      rise = bus.i_vco[c] && !m_vprev[c];
      m_vprev[c] = bus.i_vco[c];
      ev = m_dl[c][LAT-2];
      for (int j = LAT-2; j > 0; j--) m_dl[c][j] = m_dl[c][j-1];
      m_dl[c][0] = rise;
      fire = 0; retrig = 0; start = 0;
      if (!bus.i_en) begin
        m_cnt[c] = 0;
        m_rem[c] = 0;
      end else begin
        if (div == 0) m_cnt[c] = 0;
        else if (ev) begin
          if (m_cnt[c] >= div - 1) begin m_cnt[c] = 0; fire = 1; end
          else m_cnt[c]++;
        end
        if (m_rem[c] > 0) begin
          if (fire && len > 0) begin m_rem[c] = len; retrig = 1; end
          else m_rem[c]--;
        end else if (fire && len > 0) begin
          m_rem[c] = len;
          start = 1;
        end
      end
      m_miss[c] = (m_miss[c] && !bus.i_clr_status) || retrig;
      if (bus.i_clr_status) m_rate[c] = 0;
      if (start && m_rate[c] != 32'hFFFF_FFFF) m_rate[c]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vco();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) begin
      v[c] = man[c];
      if (gen_per[c] != 0) begin
        if (gen_ph[c] < gen_hi[c]) v[c] = 1'b1;
        gen_ph[c] = (gen_ph[c] + 1) % gen_per[c];
      end
    end
    bus.i_vco = v;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.i_clr_status = 1'b0;
    drive_vco();
  endtask

  task automatic pulse_ch(input logic [NUM_CH-1:0] m);
    man = m;
    drive_vco();
    repeat (4) tick();
    man = '0;
    drive_vco();
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_en = 1'b1;
    bus.i_div = DIV_W'(1);
    bus.i_spike_len = LEN_W'(1);
    bus.i_clr_status = 1'b0;
    man = '0;
    for (int c = 0; c < NUM_CH; c++) begin gen_per[c] = 0; gen_hi[c] = 0; gen_ph[c] = 0; end
    drive_vco();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.o_spike !== '0) begin n_err++; $display("FAIL reset_spike got=%b exp=0", bus.o_spike); end
    n_checks++;
    if (bus.o_miss !== '0) begin n_err++; $display("FAIL reset_miss got=%b exp=0", bus.o_miss); end
    n_checks++;
    if (bus.o_edge_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", bus.o_edge_cnt); end
  endtask

  task automatic test_latency();
    logic exp;
    do_reset();
    bus.i_div = DIV_W'(1);
    bus.i_spike_len = LEN_W'(3);
    man[0] = 1'b1;
    drive_vco();
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) man[0] = 1'b0;
      exp = (i >= 4 && i <= 6);
      n_checks++;
      if (bus.o_spike[0] !== exp) begin
        n_err++; $display("FAIL latency edge=%0d got=%b exp=%b", i, bus.o_spike[0], exp);
      end
    end
  endtask

  task automatic test_basic();
    int rises = 0, high = 0;
    logic prev = 1'b0;
    do_reset();
    bus.i_div = DIV_W'(5);
    bus.i_spike_len = LEN_W'(10);
    gen_per[0] = 20; gen_hi[0] = 10; gen_ph[0] = 0;
    drive_vco();
    for (int i = 0; i < 540; i++) begin
      tick();
      if (i == 495) gen_per[0] = 0;
      if (bus.o_spike[0] && !prev) rises++;
      if (bus.o_spike[0]) high++;
      prev = bus.o_spike[0];
      n_checks++;
      if ({bus.o_spike, bus.o_miss, bus.o_edge_cnt} !== {m_spike_v(), m_miss_v(), m_cnt_v()}) begin
        n_err++;
        $display("FAIL basic_model t=%0t spike=%b/%b miss=%b/%b cnt=%h/%h", $time, bus.o_spike,
                 m_spike_v(), bus.o_miss, m_miss_v(), bus.o_edge_cnt, m_cnt_v());
      end
    end
    n_checks++;
    if (rises != 5) begin n_err++; $display("FAIL basic_spikes got=%0d exp=5", rises); end
    n_checks++;
    if (high != 50) begin n_err++; $display("FAIL basic_high_cycles got=%0d exp=50", high); end
    n_checks++;
    if (bus.o_miss[0] !== 1'b0) begin n_err++; $display("FAIL basic_miss got=%b exp=0", bus.o_miss[0]); end
    n_checks++;
    if (bus.o_edge_cnt[0 +: DIV_W] !== '0) begin
      n_err++; $display("FAIL basic_cnt got=%0d exp=0", bus.o_edge_cnt[0 +: DIV_W]);
    end
  endtask

  task automatic test_retrigger();
    bit   seen = 0;
    int   gaps = 0;
    do_reset();
    bus.i_div = DIV_W'(2);
    bus.i_spike_len = LEN_W'(50);
    gen_per[0] = 20; gen_hi[0] = 10; gen_ph[0] = 0;
    drive_vco();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.o_spike[0]) seen = 1;
      else if (seen) gaps++;
      n_checks++;
      if ({bus.o_spike, bus.o_miss, bus.o_edge_cnt} !== {m_spike_v(), m_miss_v(), m_cnt_v()}) begin
        n_err++;
        $display("FAIL retrig_model t=%0t spike=%b/%b miss=%b/%b cnt=%h/%h", $time, bus.o_spike,
                 m_spike_v(), bus.o_miss, m_miss_v(), bus.o_edge_cnt, m_cnt_v());
      end
    end
    n_checks++;
    if (!seen || gaps != 0) begin n_err++; $display("FAIL retrig_continuous seen=%0d gaps=%0d exp gaps=0", seen, gaps); end
    n_checks++;
    if (bus.o_miss[0] !== 1'b1) begin n_err++; $display("FAIL retrig_miss_set got=%b exp=1", bus.o_miss[0]); end
    gen_per[0] = 0;
    repeat (6) tick();
    bus.i_clr_status = 1'b1;
    tick();
    n_checks++;
    if (bus.o_miss[0] !== 1'b0) begin n_err++; $display("FAIL retrig_miss_clr got=%b exp=0", bus.o_miss[0]); end
  endtask

  task automatic test_div_change();
    do_reset();
    bus.i_div = DIV_W'(10);
    bus.i_spike_len = LEN_W'(20);
    repeat (7) pulse_ch(4'b0001);
    n_checks++;
    if (bus.o_edge_cnt[0 +: DIV_W] !== DIV_W'(7)) begin
      n_err++; $display("FAIL divchg_pre_cnt got=%0d exp=7", bus.o_edge_cnt[0 +: DIV_W]);
    end
    bus.i_div = DIV_W'(3);
    pulse_ch(4'b0001);
    n_checks++;
    if (bus.o_edge_cnt[0 +: DIV_W] !== '0 || bus.o_spike[0] !== 1'b1) begin
      n_err++; $display("FAIL divchg_wrap cnt=%0d spike=%b exp cnt=0 spike=1",
                        bus.o_edge_cnt[0 +: DIV_W], bus.o_spike[0]);
    end
    bus.i_div = '0;
    repeat (25) tick();
    for (int i = 0; i < 20; i++) begin
      pulse_ch(4'b0001);
      n_checks++;
      if (bus.o_spike[0] !== 1'b0 || bus.o_edge_cnt[0 +: DIV_W] !== '0 ||
          {bus.o_spike, bus.o_edge_cnt} !== {m_spike_v(), m_cnt_v()}) begin
        n_err++; $display("FAIL div0_idle pulse=%0d spike=%b cnt=%0d exp spike=0 cnt=0",
                          i, bus.o_spike[0], bus.o_edge_cnt[0 +: DIV_W]);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    bus.i_div = DIV_W'(2);
    bus.i_spike_len = LEN_W'(20);
    bus.i_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse_ch(4'b0001);
      n_checks++;
      if (bus.o_spike !== '0 || bus.o_edge_cnt !== '0) begin
        n_err++; $display("FAIL en_off pulse=%0d spike=%b cnt=%h exp 0", i, bus.o_spike, bus.o_edge_cnt);
      end
    end
    man[0] = 1'b1;
    drive_vco();
    repeat (5) tick();
    bus.i_en = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (bus.o_edge_cnt[0 +: DIV_W] !== '0 || bus.o_spike[0] !== 1'b0) begin
      n_err++; $display("FAIL en_rise_high cnt=%0d spike=%b exp cnt=0 spike=0",
                        bus.o_edge_cnt[0 +: DIV_W], bus.o_spike[0]);
    end
    man[0] = 1'b0;
    drive_vco();
    repeat (4) tick();
    pulse_ch(4'b0001);
    n_checks++;
    if (bus.o_edge_cnt[0 +: DIV_W] !== DIV_W'(1)) begin
      n_err++; $display("FAIL en_first_edge cnt=%0d exp=1", bus.o_edge_cnt[0 +: DIV_W]);
    end
  endtask

  task automatic test_reset_mid_spike();
    do_reset();
    bus.i_div = DIV_W'(2);
    bus.i_spike_len = LEN_W'(50);
    repeat (5) pulse_ch(4'b0100);
    n_checks++;
    if (bus.o_spike[2] !== 1'b1 || bus.o_miss[2] !== 1'b1 || bus.o_edge_cnt[2*DIV_W +: DIV_W] !== DIV_W'(1)) begin
      n_err++; $display("FAIL midspike_pre spike=%b miss=%b cnt=%0d exp 1/1/1", bus.o_spike[2],
                        bus.o_miss[2], bus.o_edge_cnt[2*DIV_W +: DIV_W]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_spike !== '0) begin n_err++; $display("FAIL async_rst_spike got=%b exp=0", bus.o_spike); end
    n_checks++;
    if (bus.o_miss !== '0) begin n_err++; $display("FAIL async_rst_miss got=%b exp=0", bus.o_miss); end
    n_checks++;
    if (bus.o_edge_cnt !== '0) begin n_err++; $display("FAIL async_rst_cnt got=%h exp=0", bus.o_edge_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] prev;
    logic              clr_was;
    int                obs [NUM_CH];
    do_reset();
    bus.i_div = DIV_W'($urandom_range(1, 6));
    bus.i_spike_len = LEN_W'($urandom_range(1, 30));
    prev = '0;
    for (int c = 0; c < NUM_CH; c++) obs[c] = 0;
    for (int i = 0; i < 1200; i++) begin
      if (i % 300 == 0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          gen_per[c] = $urandom_range(6, 40);
          gen_hi[c]  = $urandom_range(2, gen_per[c] - 2);
          gen_ph[c]  = $urandom_range(0, gen_per[c] - 1);
        end
      end
      if ($urandom_range(0, 49) == 0) bus.i_clr_status = 1'b1;
      if ($urandom_range(0, 99) == 0) begin
        bus.i_div = DIV_W'($urandom_range(0, 6));
        bus.i_spike_len = LEN_W'($urandom_range(0, 30));
      end
      if ($urandom_range(0, 199) == 0) bus.i_en = ~bus.i_en;
      clr_was = bus.i_clr_status;
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_was) obs[c] = 0;
        if (bus.o_spike[c] && !prev[c]) obs[c]++;
      end
      prev = bus.o_spike;
      n_checks++;
      if ({bus.o_spike, bus.o_miss, bus.o_edge_cnt} !== {m_spike_v(), m_miss_v(), m_cnt_v()}) begin
        n_err++;
        $display("FAIL random_model t=%0t spike=%b/%b miss=%b/%b cnt=%h/%h", $time, bus.o_spike,
                 m_spike_v(), bus.o_miss, m_miss_v(), bus.o_edge_cnt, m_cnt_v());
      end
`ifdef FREQ_REDUCE_RATE_CNT_EN
      n_checks++;
      if (bus.o_rate_cnt !== m_rate_v()) begin
        n_err++; $display("FAIL random_rate t=%0t got=%h exp=%h", $time, bus.o_rate_cnt, m_rate_v());
      end
`endif
    end
`ifdef FREQ_REDUCE_RATE_CNT_EN
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if (bus.o_rate_cnt[c*32 +: 32] !== 32'(obs[c])) begin
        n_err++; $display("FAIL rate_vs_observed ch=%0d got=%0d exp=%0d", c, bus.o_rate_cnt[c*32 +: 32], obs[c]);
      end
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_retrigger();
    test_div_change();
    test_enable();
    test_reset_mid_spike();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
